// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO. Tracks FIFO occupancy
// locally so the FIFO is never pushed when full or popped when empty, issues
// registered write/read strobes, and returns popped data with a valid flag.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           gnt,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       fifo_w,
  output logic                       fifo_r,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic [WIDTH-1:0]           fifo_dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic [WIDTH-1:0] win_data;
  logic             rd_ok;
  logic             wr_ok;
  logic [CW-1:0]    count_d;
  logic [N_REQ-1:0] gnt_d;
  int               idx;

  // Pick the first requester after rr_ptr; scanning backwards lets the nearest one win.
  always_comb begin
    winner = rr_ptr;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) begin
        winner = PW'(idx);
      end
    end
    win_data = req_data[int'(winner)*WIDTH +: WIDTH];
  end

  // Decide this cycle's read/write and the resulting occupancy.
  always_comb begin
    rd_ok   = rd_req && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
    wr_ok   = (|req) && ((count < CW'(DEPTH)) || rd_ok);
    count_d = count;
    if (wr_ok && !rd_ok) begin
      count_d = count + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count - CW'(1);
    end
    gnt_d = wr_ok ? (N_REQ'(1) << winner) : '0;
  end

  // Register the decision; strobes and grant are valid during the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      fifo_w   <= 1'b0;
      fifo_r   <= 1'b0;
      rd_valid <= 1'b0;
      fifo_din <= '0;
      count    <= '0;
      rr_ptr   <= PW'(N_REQ - 1);
    end else begin
      gnt      <= gnt_d;
      fifo_w   <= wr_ok;
      fifo_r   <= rd_ok;
      // The FIFO pops on the edge after fifo_r, so its output is valid one cycle later.
      rd_valid <= fifo_r;
      count    <= count_d;
      if (wr_ok) begin
        fifo_din <= win_data;
        rr_ptr   <= winner;
      end
    end
  end

  // Status and read return are straight decodes of state and FIFO output.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    rd_data = fifo_dout;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small behavioural FIFO attached.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        rd_req;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        fifo_w;
  logic        fifo_r;
  logic [15:0] fifo_din;
  logic [15:0] fifo_dout;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks;
  int errors;

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_w(fifo_w), .fifo_r(fifo_r), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-deep FIFO: pop before push, registered data_out.
  logic [15:0] mem [4];
  logic [1:0]  wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_dout <= '0;
    end else begin
      if (fifo_r) begin
        fifo_dout <= mem[rp];
        rp <= rp + 2'd1;
      end
      if (fifo_w) begin
        mem[wp] <= fifo_din;
        wp <= wp + 2'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    rd_req = 1'b1;
    req_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || fifo_w !== 1'b0 || fifo_r !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b w=%b r=%b v=%b want 0000 0 0 0",
                 gnt, fifo_w, fifo_r, rd_valid);
      end
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL reset_count: got count=%0d empty=%b want 0 1", count, empty);
      end
    end
    rst = 1'b0;
    req = '0;
    rd_req = 1'b0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt [6];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    req = 4'b1111;
    rd_req = 1'b1;
    req_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (gnt !== exp_gnt[c]) begin
        errors++;
        $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt, exp_gnt[c]);
      end
      checks++;
      if (fifo_din !== 16'(c % 4)) begin
        errors++;
        $display("FAIL fair_din[%0d]: got %h want %h", c, fifo_din, 16'(c % 4));
      end
      if (c == 0) begin
        // Empty at the decision: the write goes through, the read must wait.
        checks++;
        if (fifo_r !== 1'b0 || count !== 3'd1) begin
          errors++;
          $display("FAIL fair_empty_rd: got r=%b count=%0d want 0 1", fifo_r, count);
        end
      end else begin
        checks++;
        if (fifo_r !== 1'b1 || count !== 3'd1) begin
          errors++;
          $display("FAIL fair_rw[%0d]: got r=%b count=%0d want 1 1", c, fifo_r, count);
        end
      end
    end
    req = '0;
    rd_req = 1'b0;
  endtask

  task automatic test_backpressure();
    int word;
    int ngnt;
    int nw;
    do_reset();
    word = 1;
    ngnt = 0;
    nw = 0;
    req = 4'b0001;
    req_data = '0;
    req_data[15:0] = 16'(word);
    for (int c = 0; c < 9; c++) begin
      tick();
      if (fifo_w) nw++;
      if (gnt[0]) begin
        ngnt++;
        checks++;
        if (fifo_din !== 16'(word)) begin
          errors++;
          $display("FAIL bp_din: got %h want %h", fifo_din, 16'(word));
        end
        word++;
        if (word > 6) req = '0;
        req_data[15:0] = 16'(word);
      end
    end
    checks++;
    if (ngnt != 4 || nw != 4) begin
      errors++;
      $display("FAIL bp_grants: got gnts=%0d writes=%0d want 4 4", ngnt, nw);
    end
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got count=%0d full=%b empty=%b want 4 1 0", count, full, empty);
    end
    req = '0;
  endtask

  task automatic test_drain();
    logic exp_r;
    logic exp_v;
    rd_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_r = (k <= 4);
      exp_v = (k >= 2 && k <= 5);
      checks++;
      if (fifo_r !== exp_r || rd_valid !== exp_v) begin
        errors++;
        $display("FAIL drain_strobe[%0d]: got r=%b v=%b want %b %b", k, fifo_r, rd_valid,
                 exp_r, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (rd_data !== 16'(k - 1)) begin
          errors++;
          $display("FAIL drain_data[%0d]: got %h want %h", k, rd_data, 16'(k - 1));
        end
      end
    end
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got count=%0d empty=%b want 0 1", count, empty);
    end
    rd_req = 1'b0;
  endtask

  task automatic fill_req0(input int n);
    int word;
    int budget;
    word = 1;
    budget = 0;
    req = 4'b0001;
    req_data = '0;
    req_data[15:0] = 16'(word);
    while (word <= n && budget < 20) begin
      tick();
      budget++;
      if (gnt[0]) begin
        word++;
        req_data[15:0] = 16'(word);
      end
    end
    req = '0;
    if (budget >= 20) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout: got %0d words want %0d", word - 1, n);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [15:0] exp_d [5];
    int idx;
    exp_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0008};
    do_reset();
    fill_req0(4);
    tick();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL sim_prefill: got count=%0d want 4", count);
    end
    req = 4'b0010;
    req_data[31:16] = 16'h0008;
    rd_req = 1'b1;
    tick();
    checks++;
    if (fifo_w !== 1'b1 || fifo_r !== 1'b1 || gnt !== 4'b0010 || count !== 3'd4) begin
      errors++;
      $display("FAIL sim_both: got w=%b r=%b gnt=%b count=%0d want 1 1 0010 4",
               fifo_w, fifo_r, gnt, count);
    end
    req = '0;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (rd_valid) begin
        checks++;
        if (idx >= 5 || rd_data !== exp_d[idx % 5]) begin
          errors++;
          $display("FAIL sim_order[%0d]: got %h want %h", idx, rd_data, exp_d[idx % 5]);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 5 || count !== 3'd0) begin
      errors++;
      $display("FAIL sim_total: got pops=%0d count=%0d want 5 0", idx, count);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    req_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    tick();
    tick();
    checks++;
    if (count !== 3'd2 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre: got count=%0d gnt=%b want 2 0010", count, gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 3'd0 || fifo_w !== 1'b0 || fifo_r !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d w=%b r=%b gnt=%b want 0 0 0 0000",
               count, fifo_w, fifo_r, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || count !== 3'd1) begin
      errors++;
      $display("FAIL mid_regrant: got gnt=%b count=%0d want 0001 1", gnt, count);
    end
    req = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    rd_req = 1'b0;
    req_data = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_drain();
    test_full_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
